// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the multi-cycle MIPS sequencer:
//                opcode constants, sequencer state encoding and the datapath
//                mux/ALU select encodings.
//                Optional feature macro: ILLEGAL_TRAP_EN (adds the HALT state).
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

   // Instruction opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operation select
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B-operand select
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Next-PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
`ifdef ILLEGAL_TRAP_EN
      S_JUMP      = 4'd10,
      S_HALT      = 4'd11
`else
      S_JUMP      = 4'd10
`endif
   } state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/retire_counter.sv
`default_nettype none
// ============================================================================
//  Module      : retire_counter
//  Description : CNT_W-bit up-counter with enable and asynchronous
//                active-low clear. Wraps silently modulo 2^CNT_W.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low clear
//                en     - increment this cycle
//                count  - current count
//  Revision    : 1.0  initial release
// ============================================================================
module retire_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : retire_counter
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle MIPS control sequencer. Walks each instruction
//                through fetch/decode/execute/memory/writeback, one datapath
//                step per clock, stalls on mem_ready and counts retirements.
//                Optional feature macro: ILLEGAL_TRAP_EN (unsupported opcodes
//                trap to HALT and set the sticky illegal_op flag).
//  Ports       : clk, rst_n         - clock, async active-low reset
//                opcode, mem_ready  - instruction opcode, memory handshake
//                pc_write .. pc_source - datapath enables and mux selects
//                instr_done         - one-cycle retirement pulse
//                retired_cnt        - retired-instruction count
//                illegal_op         - sticky illegal-opcode flag
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             illegal_op
);

   import mips_pkg::*;

   state_e     state_q, state_d;
   logic [5:0] opcode_q, opcode_d;

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      instr_done    = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            // PC+4 computed every fetch cycle; IR/PC only commit on the
            // cycle memory actually returns the instruction.
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculative branch target into ALUOut.
            alu_src_b = SRCB_IMM_SH2;
            opcode_d  = opcode;
            case (opcode)
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_d = S_HALT;
`else
                  state_d    = S_FETCH;
                  instr_done = 1'b1;
`endif
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            // Only lw/sw reach here, so the latched opcode picks the access.
            state_d   = (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            instr_done    = 1'b1;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = PCSRC_JUMP;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   always_comb begin
      illegal_d = illegal_q | (state_d == S_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

   retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (instr_done),
      .count (retired_cnt)
   );

endmodule : multicycle_control
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle opcode decode with a per-instruction state machine that walks each instruction through fetch, decode, execute, memory and writeback, one datapath step per clock. It sits beside the shared ALU/register-file/unified-memory datapath and drives every mux select and write enable. It stalls on a memory ready handshake and counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instr[31:26] from the instruction register; valid from DECODE onward
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond, ir_write, i_or_d  output  1 each  PC/IR enables; memory address select (0 = PC, 1 = ALUOut)
- mem_read, mem_write, mem_to_reg, reg_dst, reg_write  output  1 each  memory and register-file controls
- alu_src_a  output  1  0 = PC, 1 = rs
- alu_src_b  output  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse when an instruction retires
- retired_cnt  output  CNT_W  retired-instruction count; wraps modulo 2^CNT_W
- illegal_op  output  1  sticky illegal-opcode flag (ILLEGAL_TRAP_EN only; otherwise tied 0)

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP, plus HALT (macro only).
- Outputs are decoded from state, with ir_write and pc_write in FETCH also gated by mem_ready. Any output not listed for a state is 0.
  - IDLE: all outputs 0.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. The opcode is latched into an internal register here; later states use only the latched copy.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALU_WB: reg_write=1, reg_dst=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
- State transitions:
  - IDLE→FETCH unconditionally.
  - FETCH holds while mem_ready=0, then goes to DECODE.
  - DECODE dispatches on opcode:
    - 000000 → EXECUTE
    - 100011 or 101011 → MEM_ADDR
    - 000100 → BRANCH
    - 000010 → JUMP
    - other → FETCH (NOP)
  - MEM_ADDR → MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ holds until mem_ready, then goes to MEM_WB.
  - MEM_WRITE holds until mem_ready, then goes to FETCH.
  - MEM_WB, ALU_WB, BRANCH and JUMP go to FETCH.
  - EXECUTE → ALU_WB.
- Retirement:
  - instr_done=1 in MEM_WB, ALU_WB, BRANCH, JUMP, in MEM_WRITE when mem_ready=1, and in DECODE for a NOP opcode.
  - retired_cnt increments in any cycle where instr_done=1.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

## Timing
- Reset: async assert forces IDLE, latched opcode=0, retired_cnt=0, illegal_op=0, and all outputs 0. This applies even mid-instruction; no partial write enable may persist.
- Leaving reset, the first FETCH is the cycle after the first clock edge following deassertion.
- Latency in cycles with mem_ready held high (FETCH counted as cycle 1):
  - R-type 4, lw 5, sw 4, beq 3, j 3, NOP 2.
  - Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- retired_cnt updates on the clock edge ending the instr_done cycle. Wrap from all-ones to 0 is silent.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unsupported opcode in DECODE goes to HALT. HALT has all outputs 0 and is left only by reset.
  - illegal_op sets on HALT entry and stays at 1.
  - No instr_done pulse for the illegal opcode.
- ILLEGAL_TRAP_EN undefined: unsupported opcodes retire as NOP, HALT does not exist, and illegal_op is constant 0.

## Structure
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - the state enum
  - alu_op, alu_src_b and pc_source encodings
- One natural sub-module, retire_counter: a CNT_W-bit counter with enable and async active-low clear.

## Test plan
- Reset mid-MEM_READ (rst_n low for 1 cycle) → all outputs 0 immediately; retired_cnt=0; next FETCH 2 cycles after release.
- R-type (opcode 000000), mem_ready=1 → state sequence FETCH, DECODE, EXECUTE, ALU_WB; reg_write=1 and reg_dst=1 in cycle 4; instr_done single pulse; retired_cnt=1.
- lw (100011) with mem_ready=0 for 3 cycles in MEM_READ → total 8 cycles; mem_read=1, i_or_d=1 throughout MEM_READ; MEM_WB has mem_to_reg=1.
- sw (101011) then beq (000100) then j (000010), mem_ready=1 → 4+3+3 cycles; mem_write pulse 1 cycle; pc_write_cond only in BRANCH; pc_source=10 in JUMP; retired_cnt=3.
- Opcode 111111: macro undefined → NOP in 2 cycles and retired_cnt increments; macro defined → HALT with illegal_op=1, retired_cnt unchanged, mem_ready toggling has no effect.
- CNT_W=4, 16 back-to-back j instructions → retired_cnt wraps from 15 to 0.
